// File: rtl/ahb_pkg.sv
// Shared AHB-2 encodings and burst helpers for the bus arbiter.
package ahb_pkg;

  localparam int unsigned HTRANS_W = 2;
  localparam int unsigned HBURST_W = 3;
  localparam int unsigned HRESP_W  = 2;
  localparam int unsigned BEAT_W   = 4;

  typedef enum logic [HTRANS_W-1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [HBURST_W-1:0] {
    BU_SINGLE = 3'd0,
    BU_INCR   = 3'd1,
    BU_WRAP4  = 3'd2,
    BU_INCR4  = 3'd3,
    BU_WRAP8  = 3'd4,
    BU_INCR8  = 3'd5,
    BU_WRAP16 = 3'd6,
    BU_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [HRESP_W-1:0] {
    RS_OKAY  = 2'b00,
    RS_ERROR = 2'b01,
    RS_RETRY = 2'b10,
    RS_SPLIT = 2'b11
  } hresp_e;

  // Beats in a fixed burst; undefined-length INCR reports 1 so it never pins the grant.
  function automatic logic [BEAT_W:0] burst_len(input logic [HBURST_W-1:0] hburst);
    case (hburst)
      BU_WRAP4,  BU_INCR4:  burst_len = 5'd4;
      BU_WRAP8,  BU_INCR8:  burst_len = 5'd8;
      BU_WRAP16, BU_INCR16: burst_len = 5'd16;
      default:              burst_len = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arb_picker.sv
// Combinational rotate-priority picker: first set request at or after ptr (or from 0).
module ahb_arb_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             rr_en,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] index
);

  logic found;
  int   start;

  // Upper segment [start..N-1] first, then wrap around from 0.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    start = rr_en ? int'(ptr) : 0;
    for (int i = 0; i < int'(N); i++) begin
      if (!found && req[i] && (i >= start)) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        index    = IDX_W'(i);
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (!found && req[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        index    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter_param.sv
// Parametrised AHB-2 arbiter: burst-aware, lock hold, SPLIT masking, bounded INCR tenure.
module ahb_arbiter_param
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned MASTER_BITS    = 4,
  parameter int unsigned RR_MODE        = 1,
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned MAX_TENURE     = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [NUM_MASTERS-1:0] HSPLIT,
  input  logic [HTRANS_W-1:0]    HTRANS,
  input  logic [HBURST_W-1:0]    HBURST,
  input  logic                   HREADY,
  input  logic [HRESP_W-1:0]     HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MASTER_BITS-1:0] HMASTER,
  output logic                   HMASTLOCK
);

  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
  localparam int unsigned TEN_W = 16;
  localparam logic [NUM_MASTERS-1:0] DEFAULT_OH = NUM_MASTERS'(1) << DEFAULT_MASTER;

  logic [IDX_W-1:0]       gnt_idx_q, gnt_idx_n;
  logic [NUM_MASTERS-1:0] grant_n;
  logic [MASTER_BITS-1:0] master_n;
  logic                   mlock_n;
  logic [BEAT_W-1:0]      r_q, r_next;
  logic [TEN_W-1:0]       ten_q, ten_n;
  logic [NUM_MASTERS-1:0] split_q, split_n, split_set;
  logic [IDX_W-1:0]       ptr_q, ptr_n;
  logic                   rs_pend_q, rs_pend_n;

  logic                   accept, rs_first, lock_hold, permit, forced;
  logic [NUM_MASTERS-1:0] eligible, others, cand, pick_oh;
  logic [IDX_W-1:0]       pick_idx;

  ahb_arb_picker #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (cand),
    .ptr   (ptr_q),
    .rr_en (RR_MODE != 0),
    .grant (pick_oh),
    .index (pick_idx)
  );

  // Arbitration qualifiers and candidate set.
  always_comb begin
    accept    = HREADY && (HTRANS == TR_NONSEQ || HTRANS == TR_SEQ);
    rs_first  = !HREADY && (HRESP == RS_RETRY || HRESP == RS_SPLIT);
    lock_hold = HLOCK[gnt_idx_q] && HBUSREQ[gnt_idx_q];

    r_next = r_q;
    if (rs_first)
      r_next = '0;
    else if (HREADY && HTRANS == TR_NONSEQ)
      r_next = BEAT_W'(burst_len(HBURST) - 5'd1);
    else if (HREADY && HTRANS == TR_SEQ && r_q != '0)
      r_next = r_q - BEAT_W'(1);

    permit   = HREADY && (rs_pend_q || ((r_next <= BEAT_W'(1)) && !lock_hold));
    eligible = HBUSREQ & ~split_q;
    others   = eligible & ~HGRANT;
    forced   = (MAX_TENURE != 0) && (ten_q >= TEN_W'(MAX_TENURE)) &&
               (HBURST == BU_INCR) && (others != '0);
    cand     = forced ? others : eligible;
  end

  // Next-state for grant, owner, counters and split mask.
  always_comb begin
    grant_n   = HGRANT;
    gnt_idx_n = gnt_idx_q;
    ptr_n     = ptr_q;
    ten_n     = ten_q;
    master_n  = HMASTER;
    mlock_n   = HMASTLOCK;
    split_set = '0;
    rs_pend_n = rs_pend_q;

    if (accept && ten_q != '1)
      ten_n = ten_q + TEN_W'(1);

    if (permit) begin
      if (cand == '0) begin
        grant_n   = DEFAULT_OH;
        gnt_idx_n = IDX_W'(DEFAULT_MASTER);
      end else begin
        grant_n   = pick_oh;
        gnt_idx_n = pick_idx;
      end
      if (gnt_idx_n != gnt_idx_q) begin
        ten_n = '0;
        if (cand != '0)
          ptr_n = (pick_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : pick_idx + IDX_W'(1);
      end
    end

    // Owner follows the grant one accepted address phase later.
    if (HREADY) begin
      master_n = MASTER_BITS'(gnt_idx_q);
      mlock_n  = HLOCK[gnt_idx_q];
    end

    if (rs_first && HRESP == RS_SPLIT) begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (HMASTER == MASTER_BITS'(i))
          split_set[i] = 1'b1;
      end
    end
    split_n = (split_q | split_set) & ~HSPLIT;

    if (rs_first)
      rs_pend_n = 1'b1;
    else if (HREADY)
      rs_pend_n = 1'b0;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HGRANT    <= DEFAULT_OH;
      gnt_idx_q <= IDX_W'(DEFAULT_MASTER);
      HMASTER   <= MASTER_BITS'(DEFAULT_MASTER);
      HMASTLOCK <= 1'b0;
      r_q       <= '0;
      ten_q     <= '0;
      split_q   <= '0;
      ptr_q     <= '0;
      rs_pend_q <= 1'b0;
    end else begin
      HGRANT    <= grant_n;
      gnt_idx_q <= gnt_idx_n;
      HMASTER   <= master_n;
      HMASTLOCK <= mlock_n;
      r_q       <= r_next;
      ten_q     <= ten_n;
      split_q   <= split_n;
      ptr_q     <= ptr_n;
      rs_pend_q <= rs_pend_n;
    end
  end

endmodule
